// File: rtl/updown_seq_ctrl.sv
// Sequencing controller for a downstream up/down counter.
// Accepts a (direction, step count) command, issues that many single-cycle
// step enables, and keeps a mirror of the counter value. Stepping can be
// paused or aborted. Each command ends with a one-cycle done pulse.
module updown_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_steps,
  input  logic             pause,
  input  logic             abort,
  output logic             cnt_en,
  output logic             cnt_m,
  output logic [WIDTH-1:0] pos,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t           state_r, state_nxt_s;
  logic             dir_r, dir_nxt_s;
  logic [WIDTH-1:0] remaining_r, remaining_nxt_s;
  logic [WIDTH-1:0] pos_r, pos_nxt_s;
  logic             aborted_r, aborted_nxt_s;
  logic             step_s;

  // Step enable depends on the live pause/abort inputs, so it stays combinational.
  assign step_s    = (state_r == RUN) && !pause && !abort;

  assign cnt_en    = step_s;
  assign cnt_m     = (state_r == IDLE) ? 1'b0 : dir_r;
  assign pos       = pos_r;
  assign cmd_ready = (state_r == IDLE);
  assign busy      = (state_r == RUN) || (state_r == DONE);
  assign done      = (state_r == DONE);
  assign aborted   = aborted_r;
  assign wrap      = step_s && ((!dir_r && (pos_r == ALL_ONES)) ||
                                ( dir_r && (pos_r == ZERO)));

  // Next-state, latched command fields and counter mirror update.
  always_comb begin
    state_nxt_s     = state_r;
    dir_nxt_s       = dir_r;
    remaining_nxt_s = remaining_r;
    pos_nxt_s       = pos_r;
    aborted_nxt_s   = aborted_r;

    case (state_r)
      IDLE: begin
        aborted_nxt_s = 1'b0;
        if (cmd_valid) begin
          if (cmd_steps != ZERO) begin
            dir_nxt_s       = cmd_dir;
            remaining_nxt_s = cmd_steps;
            state_nxt_s     = RUN;
          end else begin
            state_nxt_s     = DONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          // Abort wins over pause; no step is taken this cycle.
          state_nxt_s   = DONE;
          aborted_nxt_s = 1'b1;
        end else if (step_s) begin
          pos_nxt_s       = dir_r ? (pos_r - ONE) : (pos_r + ONE);
          remaining_nxt_s = remaining_r - ONE;
          if (remaining_r == ONE) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        state_nxt_s   = IDLE;
        aborted_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s   = IDLE;
        aborted_nxt_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset drops any command in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      dir_r       <= 1'b0;
      remaining_r <= ZERO;
      pos_r       <= ZERO;
      aborted_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      dir_r       <= dir_nxt_s;
      remaining_r <= remaining_nxt_s;
      pos_r       <= pos_nxt_s;
      aborted_r   <= aborted_nxt_s;
    end
  end

endmodule

// File: doc/updown_seq_ctrl.md
UPDOWN_SEQ_CTRL -- requirements
Module: updown_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, width of the tracked count and the step-count field.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 cmd_valid  input  1  requester presents a command.
REQ-005 cmd_ready  output  1  controller can accept a command this cycle.
REQ-006 cmd_dir  input  1  direction: 0 = up, 1 = down.
REQ-007 cmd_steps  input  WIDTH  number of counter steps to issue; 0 is legal.
REQ-008 pause  input  1  suspends stepping while high.
REQ-009 abort  input  1  terminates the active command.
REQ-010 cnt_en  output  1  step enable to the downstream up/down counter.
REQ-011 cnt_m  output  1  mode to the downstream counter: 0 = up, 1 = down.
REQ-012 pos  output  WIDTH  controller's mirror of the downstream counter value.
REQ-013 busy  output  1  high in RUN and DONE states.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 aborted  output  1  qualifies done: high with done when the command was aborted.
REQ-016 wrap  output  1  high in any cycle where cnt_en causes pos to wrap.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a posedge with cmd_valid && cmd_ready.
REQ-019 On acceptance with cmd_steps != 0: latch cmd_dir and cmd_steps into internal dir and remaining; next state RUN.
REQ-020 On acceptance with cmd_steps == 0: no step issued; next state DONE; aborted = 0.
REQ-021 cnt_en SHALL equal (state == RUN) && !pause && !abort (combinational from registered state and inputs).
REQ-022 cnt_m SHALL equal the latched dir in RUN and DONE, and 0 in IDLE.
REQ-023 Each cycle with cnt_en = 1: pos <= pos + 1 (dir 0) or pos - 1 (dir 1), modulo 2^WIDTH; remaining <= remaining - 1.
REQ-024 In RUN, when cnt_en = 1 and remaining == 1, next state SHALL be DONE.
REQ-025 In RUN with pause = 1 and abort = 0: no step; pos and remaining hold; state stays RUN.
REQ-026 In RUN with abort = 1 (priority over pause): no step that cycle; next state DONE; aborted set for the DONE cycle.
REQ-027 abort and pause SHALL be ignored in IDLE and DONE.
REQ-028 DONE SHALL last exactly one cycle with done = 1; next state IDLE; aborted cleared on leaving DONE.
REQ-029 wrap SHALL be 1 when cnt_en = 1 and (dir 0 and pos == all ones) or (dir 1 and pos == 0); otherwise 0.
REQ-030 Latency: command accepted at edge k with N steps and no pause/abort -> cnt_en high in cycles k+1..k+N; done high in cycle k+N+1; cmd_ready high again in cycle k+N+2.
REQ-031 Back-to-back: a command presented while done = 1 SHALL NOT be accepted; it is accepted on the first IDLE cycle.
REQ-032 pos SHALL change only through REQ-023; command acceptance SHALL NOT alter pos.

Reset
REQ-033 While reset = 1 at posedge clk: state = IDLE, pos = 0, remaining = 0, dir = 0, aborted = 0; this gives cnt_en = 0, cnt_m = 0, done = 0, busy = 0, wrap = 0, cmd_ready = 1 after the edge.
REQ-034 Reset SHALL take priority over all inputs, including mid-RUN; a command in flight is dropped without a done pulse.

Verification
REQ-035 Reset, then cmd up with steps = 3 -> cnt_en high for 3 cycles with cnt_m = 0, pos 0->3, done pulse on the next cycle with aborted = 0.
REQ-036 pos = 3, cmd down with steps = 5 -> pos 3,2,1,0,15,14; wrap = 1 only in the cycle stepping 0->15; done follows.
REQ-037 cmd up with steps = 4, pause high for 2 cycles after the 2nd step -> 4 steps total, done delayed by exactly 2 cycles, pos ends +4.
REQ-038 cmd up with steps = 6, abort after 2 steps with pause also high -> no step in the abort cycle, done = 1 and aborted = 1 next cycle, pos = start + 2.
REQ-039 cmd with steps = 0 -> no cnt_en, done pulse the cycle after acceptance, pos unchanged.
REQ-040 reset asserted mid-RUN (steps = 7, after 3 steps) -> next cycle IDLE, pos = 0, no done pulse, cmd_ready = 1.
